// File: rtl/uart_tx_buf.sv
// uart_tx_buf: FIFO-buffered UART transmitter, 8N1, LSB first, idle-high TX line.
// Define UART_TX_PARITY_EN to add an even-parity bit, which gives 11-bit frames.
module uart_tx_buf #(
  parameter int BAUD_DIV   = 2604,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       full,
  output logic       busy,
  output logic       tx_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam logic [11:0] BAUD_RELOAD = 12'(BAUD_DIV - 1);
  localparam logic [3:0]  LAST_BIT    = 4'(FRAME_BITS - 1);

  typedef enum logic {IDLE = 1'b0, XMIT = 1'b1} state_e;

  logic [7:0]            mem_q [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [7:0]            head;

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [11:0]           baud_cnt_q, baud_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  tx_done_q, tx_done_d;
  logic                  baud_tick;
  logic                  frame_end;
  logic                  load_frame;
  logic                  set_done;
  logic [FRAME_BITS-1:0] frame_word;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push  = trmt && !full;
  assign pop   = load_frame;
  assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

  assign wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= tx_data;
    end
  end

`ifdef UART_TX_PARITY_EN
  assign frame_word = {1'b1, ^head, head, 1'b0};
`else
  assign frame_word = {1'b1, head, 1'b0};
`endif

  // The frame ends on the tick that completes the stop bit, so a queued
  // byte can be loaded on that same edge with no idle gap.
  assign baud_tick = (baud_cnt_q == 12'd0);
  assign frame_end = (state_q == XMIT) && baud_tick && (bit_cnt_q == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = XMIT;
      XMIT:    if (frame_end && empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_frame = 1'b0;
    set_done   = 1'b0;
    case (state_q)
      IDLE: load_frame = !empty;
      XMIT: begin
        load_frame = frame_end && !empty;
        set_done   = frame_end && empty;
      end
      default: begin
        load_frame = 1'b0;
        set_done   = 1'b0;
      end
    endcase
  end

  always_comb begin
    shift_d    = shift_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (load_frame) begin
      shift_d    = frame_word;
      baud_cnt_d = BAUD_RELOAD;
      bit_cnt_d  = 4'd0;
    end else if (state_q == XMIT) begin
      if (baud_tick) begin
        shift_d    = {1'b1, shift_q[FRAME_BITS-1:1]};
        baud_cnt_d = BAUD_RELOAD;
        bit_cnt_d  = bit_cnt_q + 4'd1;
      end else begin
        baud_cnt_d = baud_cnt_q - 12'd1;
      end
    end
  end

  // An accepted push means more data is coming, so it overrides the set.
  always_comb begin
    tx_done_d = tx_done_q;
    if (push) begin
      tx_done_d = 1'b0;
    end else if (set_done) begin
      tx_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      shift_q    <= '1;
      baud_cnt_q <= 12'd0;
      bit_cnt_q  <= 4'd0;
      tx_done_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      shift_q    <= shift_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign TX      = shift_q[0];
  assign busy    = (state_q == XMIT);
  assign tx_done = tx_done_q;

endmodule
